rs2_sel_ctrl: RTL and testbench

- Controller that sequences the EX-stage ALU operand-B select (`rs2muxsel`) of the 5-stage core.
- Registers the ID→EX select, detects RAW hazards against the instruction currently in EX, and chooses between the register value and ALUOUT forwarding.
- Inserts one bubble on load-use hazards and freezes on memory back-pressure.
- Sits between the decoder and the EX:MEM operand-B mux.

---
 rtl/rs2_sel_ctrl_pkg.sv | 26 ++
 rtl/rs2_sel_ctrl_hazard_cmp.sv | 19 +
 rtl/rs2_sel_ctrl.sv | 109 ++++++++++
 tb/tb_rs2_sel_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rs2_sel_ctrl_pkg.sv
// rs2_sel_pkg: operand-B opclass/select encodings, controller state enum, base select helper
package rs2_sel_pkg;
  typedef enum logic [2:0] {
    OPC_NONE = 3'd0,
    OPC_RR   = 3'd1,
    OPC_LSJ  = 3'd2,
    OPC_AUI  = 3'd3,
    OPC_LS32 = 3'd4
  } opclass_e;
  localparam logic [2:0] SEL_RS2    = 3'b000;
  localparam logic [2:0] SEL_ALUOUT = 3'b001;
  localparam logic [2:0] SEL_LSJ    = 3'b010;
  localparam logic [2:0] SEL_AUI    = 3'b011;
  localparam logic [2:0] SEL_LS32   = 3'b100;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;
  // reserved opclasses fall back to the register value
  function automatic logic [2:0] base_sel(input logic [2:0] opc);
    return opc == OPC_LSJ  ? SEL_LSJ :
           opc == OPC_AUI  ? SEL_AUI :
           opc == OPC_LS32 ? SEL_LS32 : SEL_RS2;
  endfunction
endpackage

// File: rtl/rs2_sel_ctrl_hazard_cmp.sv
// rs2_hazard_cmp: RAW detection of an ID source register against the EX destination
// Ports: id_valid/id_uses_rs2/id_rs2 from ID; ex_valid/ex_rd_we/ex_is_load/ex_rd from EX tracking;
//        raw = EX writes the register ID reads (x0 excluded), raw_load = raw with a load in EX.
module rs2_hazard_cmp #(
  parameter int AW = 5
) (
  input  logic          id_valid,
  input  logic          id_uses_rs2,
  input  logic [AW-1:0] id_rs2,
  input  logic          ex_valid,
  input  logic          ex_rd_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  output logic          raw,
  output logic          raw_load
);
  assign raw      = id_valid & id_uses_rs2 & ex_valid & ex_rd_we & (ex_rd != '0) & (ex_rd == id_rs2);
  assign raw_load = raw & ex_is_load;
endmodule

// File: rtl/rs2_sel_ctrl.sv
// rs2_sel_ctrl: EX-stage operand-B select sequencer with forwarding, load-use bubble and memory freeze
// Ports: clk, rst (sync, active-high); id_* decoded ID instruction fields; mem_ready (low freezes ID/EX);
//        rs2muxsel/ex_valid registered EX outputs; id_stall combinational ID hold; stall_cnt saturating.
// Build option: define RS2_FWD_EN to forward ALUOUT on RR hazards; otherwise every RR hazard bubbles.
module rs2_sel_ctrl
  import rs2_sel_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int XLEN_REGS   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [2:0]                     id_opclass,
  input  logic                           id_uses_rs2,
  input  logic [$clog2(XLEN_REGS)-1:0]   id_rs2,
  input  logic [$clog2(XLEN_REGS)-1:0]   id_rd,
  input  logic                           id_rd_we,
  input  logic                           id_is_load,
  input  logic                           mem_ready,
  output logic [2:0]                     rs2muxsel,
  output logic                           ex_valid,
  output logic                           id_stall,
  output logic [STALL_CNT_W-1:0]         stall_cnt
);
  localparam int AW = $clog2(XLEN_REGS);
  state_e state, state_nx, ret, ret_nx;
  logic [AW-1:0] ex_rd;
  logic ex_rd_we, ex_is_load, raw, raw_load, is_rr, lu_hz, fwd, adv, bubble;
  rs2_hazard_cmp #(.AW(AW)) u_cmp (
    .id_valid   (id_valid),
    .id_uses_rs2(id_uses_rs2),
    .id_rs2     (id_rs2),
    .ex_valid   (ex_valid),
    .ex_rd_we   (ex_rd_we),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .raw        (raw),
    .raw_load   (raw_load)
  );
  assign is_rr = id_opclass == OPC_RR;
`ifdef RS2_FWD_EN
  assign lu_hz = raw_load;
  assign fwd   = raw & is_rr;
`else
  assign lu_hz = raw_load | (raw & is_rr);
  assign fwd   = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    adv      = 1'b0;
    bubble   = 1'b0;
    id_stall = 1'b0;
    case (state)
      ST_RUN: begin
        if (!mem_ready) begin
          state_nx = ST_MEM_WAIT;
          ret_nx   = ST_RUN;
          id_stall = 1'b1;
        end else if (lu_hz) begin
          state_nx = ST_LU_STALL;
          id_stall = 1'b1;
          bubble   = 1'b1;
        end else adv = 1'b1;
      end
      // EX already holds the bubble, so raw is clear here and the held instruction takes its base select
      ST_LU_STALL: begin
        state_nx = mem_ready ? ST_RUN : ST_MEM_WAIT;
        ret_nx   = mem_ready ? ret : ST_LU_STALL;
        adv      = mem_ready;
      end
      ST_MEM_WAIT: begin
        id_stall = 1'b1;
        state_nx = mem_ready ? ret : ST_MEM_WAIT;
      end
      default: state_nx = ST_RUN;
    endcase
    if (rst) id_stall = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      ret        <= ST_RUN;
      rs2muxsel  <= SEL_RS2;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_rd_we   <= 1'b0;
      ex_is_load <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      if (adv) begin
        rs2muxsel  <= fwd ? SEL_ALUOUT : base_sel(id_opclass);
        ex_valid   <= id_valid;
        ex_rd      <= id_rd;
        ex_rd_we   <= id_rd_we;
        ex_is_load <= id_is_load;
      end else if (bubble) begin
        rs2muxsel  <= SEL_RS2;
        ex_valid   <= 1'b0;
        ex_rd_we   <= 1'b0;
        ex_is_load <= 1'b0;
      end
      if (id_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rs2_sel_ctrl.sv
// tb_rs2_sel_ctrl: scoreboard bench for rs2_sel_ctrl (counter narrowed to 4 bits to reach saturation)
module tb_rs2_sel_ctrl;
  import rs2_sel_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 1'b0, id_uses_rs2 = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0, mem_ready = 1'b1;
  logic [2:0] id_opclass = 3'd0;
  logic [4:0] id_rs2 = 5'd0, id_rd = 5'd0;
  logic [2:0] rs2muxsel;
  logic ex_valid, id_stall;
  logic [3:0] stall_cnt;
  int n_run = 0, n_fail = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_e;
  always #5 clk = ~clk;
  rs2_sel_ctrl #(.STALL_CNT_W(4), .XLEN_REGS(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opclass(id_opclass), .id_uses_rs2(id_uses_rs2),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .mem_ready(mem_ready),
    .rs2muxsel(rs2muxsel), .ex_valid(ex_valid), .id_stall(id_stall), .stall_cnt(stall_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] opc, input logic u, input logic [4:0] r2,
                       input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_opclass = opc; id_uses_rs2 = u; id_rs2 = r2; id_rd = rd; id_rd_we = we; id_is_load = ld;
  endtask
  task automatic idle();
    drive(1'b0, OPC_NONE, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic cyc(input string tag, input logic mr, input logic e_stall, input logic [2:0] e_sel, input logic e_val);
    mem_ready = mr;
    #1;
    check({tag, ".stall"}, id_stall, e_stall);
    sb.push_back({e_sel, e_val});
    @(posedge clk);
    #1;
    exp_e = sb.pop_front();
    check({tag, ".sel"}, rs2muxsel, exp_e[3:1]);
    check({tag, ".valid"}, ex_valid, exp_e[0]);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc("rst", 1'b1, 1'b0, SEL_RS2, 1'b0);
    check("rst.cnt", stall_cnt, 0);
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    drive(1, OPC_RR, 0, 5'd0, 5'd5, 1, 0);
    cyc("add5", 1, 0, SEL_RS2, 1);
    drive(1, OPC_RR, 1, 5'd5, 5'd6, 1, 0);
`ifdef RS2_FWD_EN
    cyc("fwd", 1, 0, SEL_ALUOUT, 1);
    check("fwd.cnt", stall_cnt, 0);
`else
    cyc("nofwd.stall", 1, 1, SEL_RS2, 0);
    cyc("nofwd.adv", 1, 0, SEL_RS2, 1);
    check("nofwd.cnt", stall_cnt, 1);
`endif
    idle();
    cyc("idle", 1, 0, SEL_RS2, 0);
    do_reset();
    drive(1, OPC_LSJ, 0, 5'd0, 5'd7, 1, 1);
    cyc("lw7", 1, 0, SEL_LSJ, 1);
    drive(1, OPC_RR, 1, 5'd7, 5'd8, 1, 0);
    cyc("lu.stall", 1, 1, SEL_RS2, 0);
    cyc("lu.adv", 1, 0, SEL_RS2, 1);
    check("lu.cnt", stall_cnt, 1);
    do_reset();
    drive(1, OPC_RR, 0, 5'd0, 5'd0, 1, 0);
    cyc("x0.prod", 1, 0, SEL_RS2, 1);
    drive(1, OPC_RR, 1, 5'd0, 5'd3, 1, 0);
    cyc("x0.cons", 1, 0, SEL_RS2, 1);
    check("x0.cnt", stall_cnt, 0);
    for (int k = 2; k <= 4; k++) begin
      drive(1, OPC_RR, 0, 5'd0, 5'd9, 1, 0);
      cyc("sweep.prod", 1, 0, SEL_RS2, 1);
      drive(1, 3'(k), 1, 5'd9, 5'd10, 0, 0);
      cyc($sformatf("sweep%0d", k), 1, 0, base_sel(3'(k)), 1);
    end
    check("sweep.cnt", stall_cnt, 0);
    do_reset();
    drive(1, OPC_LSJ, 0, 5'd0, 5'd7, 1, 1);
    cyc("mw.lw", 1, 0, SEL_LSJ, 1);
    drive(1, OPC_RR, 1, 5'd7, 5'd8, 1, 0);
    cyc("mw.lu", 1, 1, SEL_RS2, 0);
    cyc("mw.hold1", 0, 0, SEL_RS2, 0);
    cyc("mw.hold2", 0, 1, SEL_RS2, 0);
    cyc("mw.hold3", 0, 1, SEL_RS2, 0);
    cyc("mw.release", 1, 1, SEL_RS2, 0);
    cyc("mw.adv", 1, 0, SEL_RS2, 1);
    check("mw.cnt", stall_cnt, 4);
    drive(1, OPC_AUI, 0, 5'd0, 5'd11, 1, 0);
    cyc("mw.freeze", 0, 1, SEL_RS2, 1);
    cyc("mw.unfreeze", 1, 1, SEL_RS2, 1);
    cyc("mw.aui", 1, 0, SEL_AUI, 1);
    check("mw.cnt2", stall_cnt, 6);
    do_reset();
    idle();
    for (int k = 0; k < 20; k++) cyc("sat", 0, 1, SEL_RS2, 0);
    check("sat.cnt", stall_cnt, 15);
    cyc("sat.exit", 1, 1, SEL_RS2, 0);
    check("sat.hold", stall_cnt, 15);
    do_reset();
    drive(1, OPC_LSJ, 0, 5'd0, 5'd7, 1, 1);
    cyc("rl.lw", 1, 0, SEL_LSJ, 1);
    drive(1, OPC_RR, 1, 5'd7, 5'd8, 1, 0);
    cyc("rl.lu", 1, 1, SEL_RS2, 0);
    check("rl.cnt", stall_cnt, 1);
    rst = 1'b1;
    cyc("rl.rst", 1, 0, SEL_RS2, 0);
    check("rl.rstcnt", stall_cnt, 0);
    rst = 1'b0;
    cyc("rl.run", 1, 0, SEL_RS2, 1);
    check("rl.cnt2", stall_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
